// File: rtl/fft_sram_arbiter_if.sv
// fft_sram_arbiter_if
//   Requester-side bus of the FFT SRAM arbiter.
//
//   Handshake: a requester holds req[i] (with we[i], addr<i>, wdata<i>) high
//   until it sees gnt[i]; gnt is a one-cycle pulse coincident with the SRAM
//   access, and the requester must update or drop req[i] on the following
//   edge. Reads come back later as a one-cycle rvalid pulse tagged by rid.
//
//   Signals:
//     req[2:0]      request per requester (0 host, 1 bfly read, 2 bfly write)
//     we[2:0]       per-requester write flag (1 = write)
//     addr0..addr2  per-requester 16-bit SRAM word address
//     wdata0..2     per-requester 32-bit write data
//     gnt[2:0]      one-hot grant pulse
//     rvalid        read data valid pulse
//     rid[1:0]      requester index owning rdata
//     rdata[31:0]   read data
//   Modports: master (requester side), slave (arbiter side).
interface fft_sram_arbiter_if;
    logic [2:0]  req;
    logic [2:0]  we;
    logic [15:0] addr0;
    logic [15:0] addr1;
    logic [15:0] addr2;
    logic [31:0] wdata0;
    logic [31:0] wdata1;
    logic [31:0] wdata2;
    logic [2:0]  gnt;
    logic        rvalid;
    logic [1:0]  rid;
    logic [31:0] rdata;

    modport master (
        output req, we, addr0, addr1, addr2, wdata0, wdata1, wdata2,
        input  gnt, rvalid, rid, rdata
    );

    modport slave (
        input  req, we, addr0, addr1, addr2, wdata0, wdata1, wdata2,
        output gnt, rvalid, rid, rdata
    );
endinterface

// File: rtl/fft_sram_arbiter.sv
// fft_sram_arbiter
//   Single-port SRAM arbiter for an FFT engine: host load/unload (0),
//   butterfly read path (1) and butterfly write path (2). One access per
//   cycle, round-robin, every output registered.
//
//   Ports:
//     clk             clock, rising edge
//     n_rst           asynchronous active-low reset
//     bus             fft_sram_arbiter_if.slave requester bus
//     sram_read_ena   SRAM read strobe
//     sram_write_ena  SRAM write strobe
//     sram_addr       SRAM address (holds last value when idle)
//     sram_wdata      SRAM write data (holds last value when idle)
//     sram_rdata      SRAM read data; sampled at the end of the read strobe
//                     cycle and presented on rdata with rvalid one cycle later
//     busy            high in ACCESS and RETURN
//     state_dbg       FSM state for debug: 0 IDLE, 1 ACCESS, 2 RETURN
//
//   Configuration macro: FFT_ARB_HOST_PRIORITY_EN -- when defined, requester 0
//   wins whenever eligible and round-robin runs only between 1 and 2.
module fft_sram_arbiter (
    input  logic                     clk,
    input  logic                     n_rst,
    fft_sram_arbiter_if.slave        bus,
    output logic                     sram_read_ena,
    output logic                     sram_write_ena,
    output logic [15:0]              sram_addr,
    output logic [31:0]              sram_wdata,
    input  logic [31:0]              sram_rdata,
    output logic                     busy,
    output logic [1:0]               state_dbg
);
    localparam int NREQ = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RETURN = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            rd_q, rd_d;
    logic            wr_q, wr_d;
    logic [15:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [1:0]      idx_q, idx_d;    // requester owning the current access
    logic [1:0]      ptr_q, ptr_d;    // last round-robin winner
    logic            rvalid_q, rvalid_d;
    logic [1:0]      rid_q, rid_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            busy_q, busy_d;

    // Arbitration: the requester holding the grant this cycle is masked.
    logic [3:0]      elig;
    logic            any_elig;
    logic [1:0]      win;
    logic [1:0]      c0, c1;

    always_comb begin
        elig     = {1'b0, bus.req & ~gnt_q};
        any_elig = |elig[NREQ-1:0];
        win      = 2'd0;
        c0       = 2'd0;
        c1       = 2'd0;
`ifdef FFT_ARB_HOST_PRIORITY_EN
        // Host first; ptr only remembers the last 1-vs-2 winner.
        c0 = (ptr_q == 2'd1) ? 2'd2 : 2'd1;
        c1 = (ptr_q == 2'd1) ? 2'd1 : 2'd2;
        if (elig[0])       win = 2'd0;
        else if (elig[c0]) win = c0;
        else               win = c1;
`else
        // Search order: ptr+1, ptr+2, ptr (mod 3).
        c0 = (ptr_q == 2'd2) ? 2'd0 : ptr_q + 2'd1;
        c1 = (c0 == 2'd2) ? 2'd0 : c0 + 2'd1;
        if (elig[c0])      win = c0;
        else if (elig[c1]) win = c1;
        else               win = ptr_q;
`endif
    end

    // State register and all registered outputs.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            idx_q    <= 2'd0;
            ptr_q    <= 2'd2;
            rvalid_q <= 1'b0;
            rid_q    <= 2'd0;
            rdata_q  <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            idx_q    <= idx_d;
            ptr_q    <= ptr_d;
            rvalid_q <= rvalid_d;
            rid_q    <= rid_d;
            rdata_q  <= rdata_d;
            busy_q   <= busy_d;
        end
    end

    // Next state.
    always_comb begin
        state_d = IDLE;
        if (any_elig)
            state_d = ACCESS;
        else if (state_q == ACCESS && rd_q)
            state_d = RETURN;
    end

    // Next values of the registered outputs.
    always_comb begin
        gnt_d   = '0;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        if (any_elig) begin
            gnt_d = 3'b001 << win;
            wr_d  = bus.we[win];
            rd_d  = ~bus.we[win];
            idx_d = win;
            case (win)
                2'd0: begin
                    addr_d  = bus.addr0;
                    wdata_d = bus.wdata0;
                end
                2'd1: begin
                    addr_d  = bus.addr1;
                    wdata_d = bus.wdata1;
                end
                default: begin
                    addr_d  = bus.addr2;
                    wdata_d = bus.wdata2;
                end
            endcase
`ifdef FFT_ARB_HOST_PRIORITY_EN
            if (win != 2'd0)
                ptr_d = win;
`else
            ptr_d = win;
`endif
        end
        // A read issued this cycle returns on the next one; rid/rdata hold otherwise.
        rvalid_d = rd_q;
        rid_d    = rd_q ? idx_q : rid_q;
        rdata_d  = rd_q ? sram_rdata : rdata_q;
        busy_d   = (state_d != IDLE);
    end

    assign bus.gnt        = gnt_q;
    assign bus.rvalid     = rvalid_q;
    assign bus.rid        = rid_q;
    assign bus.rdata      = rdata_q;
    assign sram_read_ena  = rd_q;
    assign sram_write_ena = wr_q;
    assign sram_addr      = addr_q;
    assign sram_wdata     = wdata_q;
    assign busy           = busy_q;
    assign state_dbg      = state_q;
endmodule

// File: tb/tb_fft_sram_arbiter.sv
// tb_fft_sram_arbiter
//   Directed and randomized bench for fft_sram_arbiter with a behavioural
//   reference model (round-robin by modular search, SRAM as an array, read
//   returns as a one-deep pending slot). Honors FFT_ARB_HOST_PRIORITY_EN.
module tb_fft_sram_arbiter;
    logic        clk = 1'b0;
    logic        n_rst;
    logic        sram_read_ena;
    logic        sram_write_ena;
    logic [15:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;
    logic        busy;
    logic [1:0]  state_dbg;

    fft_sram_arbiter_if bus();

    fft_sram_arbiter dut (
        .clk            (clk),
        .n_rst          (n_rst),
        .bus            (bus),
        .sram_read_ena  (sram_read_ena),
        .sram_write_ena (sram_write_ena),
        .sram_addr      (sram_addr),
        .sram_wdata     (sram_wdata),
        .sram_rdata     (sram_rdata),
        .busy           (busy),
        .state_dbg      (state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- SRAM device model ----------------
    // Unwritten words read back as a fixed function of the address.
    function automatic logic [31:0] init_word(input int a);
        return 32'h1234_5673 + 32'(a);
    endfunction

    logic [31:0] sram_mem [0:255];
    bit          sram_wr  [0:255];
    assign sram_rdata = sram_wr[sram_addr[7:0]] ? sram_mem[sram_addr[7:0]]
                                                : init_word(int'(sram_addr[7:0]));
    always @(posedge clk) begin
        if (sram_write_ena) begin
            sram_mem[sram_addr[7:0]] <= sram_wdata;
            sram_wr[sram_addr[7:0]]  <= 1'b1;
        end
    end

`ifdef FFT_ARB_HOST_PRIORITY_EN
    localparam int MAX_GAP = 4;
`else
    localparam int MAX_GAP = 3;
`endif

    // ---------------- scoreboard / reference model ----------------
    int          checks = 0;
    int          errors = 0;
    logic [31:0] ref_mem [0:255];
    int          last_rr, last_hi, prev_w;
    bit          pend_rd;
    int          pend_id;
    logic [31:0] pend_data;
    logic [31:0] exp_q[$];     // expected rdata of reads in flight
    logic [2:0]  exp_gnt;
    logic        exp_rd, exp_wr, exp_rvalid, exp_busy;
    logic [15:0] exp_addr;
    logic [31:0] exp_wdata, exp_rdata;
    logic [1:0]  exp_rid;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] addr_of(input int w);
        return (w == 0) ? bus.addr0 : (w == 1) ? bus.addr1 : bus.addr2;
    endfunction

    function automatic logic [31:0] wdata_of(input int w);
        return (w == 0) ? bus.wdata0 : (w == 1) ? bus.wdata1 : bus.wdata2;
    endfunction

    // Winner for the coming edge, or -1 if nobody is eligible.
    function automatic int pick();
        bit [2:0] el;
        int       first;
        for (int i = 0; i < 3; i++) el[i] = bus.req[i] && (i != prev_w);
`ifdef FFT_ARB_HOST_PRIORITY_EN
        if (el[0]) return 0;
        first = (last_hi == 1) ? 2 : 1;
        if (el[first]) return first;
        if (el[3 - first]) return 3 - first;
        return -1;
`else
        first = 0;
        for (int k = 1; k <= 3; k++) begin
            first = (last_rr + k) % 3;
            if (el[first]) return first;
        end
        return -1;
`endif
    endfunction

    task automatic model_reset();
        last_rr = 2; last_hi = 2; prev_w = -1;
        pend_rd = 0; pend_id = 0; pend_data = '0;
        exp_q.delete();
        exp_gnt = '0; exp_rd = 0; exp_wr = 0; exp_rvalid = 0; exp_busy = 0;
        exp_addr = '0; exp_wdata = '0; exp_rdata = '0; exp_rid = '0;
    endtask

    task automatic check_all(input string tag);
        check({tag, "_gnt"},    64'(bus.gnt),        64'(exp_gnt));
        check({tag, "_rd"},     64'(sram_read_ena),  64'(exp_rd));
        check({tag, "_wr"},     64'(sram_write_ena), 64'(exp_wr));
        check({tag, "_addr"},   64'(sram_addr),      64'(exp_addr));
        check({tag, "_wdata"},  64'(sram_wdata),     64'(exp_wdata));
        check({tag, "_rvalid"}, 64'(bus.rvalid),     64'(exp_rvalid));
        check({tag, "_rid"},    64'(bus.rid),        64'(exp_rid));
        check({tag, "_rdata"},  64'(bus.rdata),      64'(exp_rdata));
        check({tag, "_busy"},   64'(busy),           64'(exp_busy));
    endtask

    // ---------------- driver: one clock with model prediction ----------------
    task automatic step(input string tag);
        int          w;
        logic [15:0] a;
        logic [31:0] d;
        exp_rvalid = pend_rd;
        if (pend_rd) begin
            exp_rid   = 2'(pend_id);
            exp_rdata = exp_q.pop_front();
        end
        w = pick();
        if (w >= 0) begin
            a         = addr_of(w);
            d         = wdata_of(w);
            exp_gnt   = 3'(1 << w);
            exp_wr    = bus.we[w];
            exp_rd    = !bus.we[w];
            exp_addr  = a;
            exp_wdata = d;
            if (bus.we[w]) ref_mem[a[7:0]] = d;
            else exp_q.push_back(ref_mem[a[7:0]]);
            pend_rd = !bus.we[w];
            pend_id = w;
            last_rr = w;
            if (w != 0) last_hi = w;
        end else begin
            exp_gnt = '0; exp_wr = 0; exp_rd = 0; pend_rd = 0;
        end
        prev_w   = w;
        exp_busy = (w >= 0) || exp_rvalid;
        @(posedge clk); #1;
        check_all(tag);
    endtask

    task automatic drive(input logic [2:0] r, input logic [2:0] wv);
        bus.req = r;
        bus.we  = wv;
    endtask

    // ---------------- stimulus ----------------
    int since [0:2];
    int seq_id[$];

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        model_reset();
        n_rst = 1'b0;
        drive(3'b000, 3'b000);
        bus.addr0 = 16'd10; bus.addr1 = 16'd11; bus.addr2 = 16'd12;
        bus.wdata0 = $urandom; bus.wdata1 = $urandom; bus.wdata2 = $urandom;
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");
        check("reset_state", 64'(state_dbg), 64'(0));
        n_rst = 1'b1;

        // All three requesting reads after reset.
`ifdef FFT_ARB_HOST_PRIORITY_EN
        seq_id = '{0, 1, 0, 2, 0};
`else
        seq_id = '{0, 1, 2, 0};
`endif
        drive(3'b111, 3'b000);
        foreach (seq_id[i]) begin
            step("rr");
            check("rr_seq_gnt", 64'(bus.gnt), 64'(1 << seq_id[i]));
            if (i > 0) begin
                check("rr_seq_rvalid", 64'(bus.rvalid), 64'(1));
                check("rr_seq_rid", 64'(bus.rid), 64'(seq_id[i - 1]));
            end
        end
        drive(3'b000, 3'b000);
        step("rr_drain");
        check("rr_last_rid", 64'(bus.rid), 64'(seq_id[seq_id.size() - 1]));
        step("rr_idle");

        // Lone write by requester 2.
        bus.addr2 = 16'h0040; bus.wdata2 = 32'hDEAD_BEEF;
        drive(3'b100, 3'b100);
        step("wr");
        check("wr_gnt", 64'(bus.gnt), 64'(3'b100));
        check("wr_ena", 64'(sram_write_ena), 64'(1));
        check("wr_addr", 64'(sram_addr), 64'(16'h0040));
        check("wr_data", 64'(sram_wdata), 64'(32'hDEAD_BEEF));
        drive(3'b000, 3'b000);
        step("wr_after");
        check("wr_no_rvalid", 64'(bus.rvalid), 64'(0));
        check("wr_idle_state", 64'(state_dbg), 64'(0));

        // Single read by requester 1 at address 5.
        bus.addr1 = 16'h0005;
        drive(3'b010, 3'b000);
        step("rd");
        check("rd_gnt", 64'(bus.gnt), 64'(3'b010));
        drive(3'b000, 3'b000);
        step("rd_ret");
        check("rd_rvalid", 64'(bus.rvalid), 64'(1));
        check("rd_rid", 64'(bus.rid), 64'(1));
        check("rd_rdata", 64'(bus.rdata), 64'(32'h1234_5678));
        check("rd_state_return", 64'(state_dbg), 64'(2));
        step("rd_end");
        check("rd_state_idle", 64'(state_dbg), 64'(0));
        check("rd_busy_low", 64'(busy), 64'(0));

        // Reset pulsed while a read return is pending.
        bus.addr0 = 16'h0021;
        drive(3'b001, 3'b000);
        step("rst_rd");
        drive(3'b000, 3'b000);
        #3;
        n_rst = 1'b0;
        #1;
        model_reset();
        check_all("rst_mid");
        check("rst_mid_state", 64'(state_dbg), 64'(0));
        @(posedge clk); #1;
        n_rst = 1'b1;
        step("rst_after");
        check("rst_no_rvalid", 64'(bus.rvalid), 64'(0));
        step("rst_after2");
        drive(3'b111, 3'b000);
        step("rst_first");
        check("rst_first_gnt", 64'(bus.gnt), 64'(3'b001));
        drive(3'b000, 3'b000);
        step("rst_drain");
        step("rst_drain2");

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            bus.req    = 3'($urandom_range(0, 7));
            bus.we     = 3'($urandom_range(0, 7));
            bus.addr0  = 16'($urandom_range(0, 255));
            bus.addr1  = 16'($urandom_range(0, 255));
            bus.addr2  = 16'($urandom_range(0, 255));
            bus.wdata0 = $urandom;
            bus.wdata1 = $urandom;
            bus.wdata2 = $urandom;
            step("rand");
        end

        // Continuous requests: every requester is served within the bound.
        for (int i = 0; i < 3; i++) since[i] = 0;
        bus.req = 3'b111;
        for (int n = 0; n < 12; n++) begin
            bus.we = 3'($urandom_range(0, 7));
            step("fair");
            for (int i = 0; i < 3; i++) begin
                since[i] = bus.gnt[i] ? 0 : since[i] + 1;
                check("fair_gap", 64'(since[i] < MAX_GAP), 64'(1));
            end
        end
        drive(3'b000, 3'b000);
        step("final_drain");
        step("final_idle");
        check("final_state", 64'(state_dbg), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
